// File: rtl/stack_queue_buffer.sv
// stack_queue_buffer
//   Dual-mode LIFO/FIFO storage built on one circular buffer. Pushes always
//   append at the tail. Pops take the tail (stack) or the head (queue), so
//   the mode can change while the buffer holds data.
//
// Ports
//   clk       rising-edge system clock
//   rst       asynchronous active-high reset
//   data_in   word to push
//   push      push request (one request per high cycle)
//   pop       pop request (one request per high cycle)
//   sel       mode select: 0 = stack (LIFO), 1 = queue (FIFO)
//   data_out  element the next pop would remove, 0 when empty
//   empty     count == 0
//   full      count == DEPTH
//   count     number of stored entries
//   err       one-cycle registered pulse after a rejected request
//
// Build option
//   SQ_MODE_LOCK_EN  when defined, the mode is a register that is loaded
//                    from sel only while the buffer is empty.
module stack_queue_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              push,
  input  logic              pop,
  input  logic              sel,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [AW-1:0]     tail_m1;
  logic              m;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     head_nxt;
  logic [AW-1:0]     tail_nxt;
  logic [AW:0]       count_nxt;
  logic              err_nxt;

  // Pointers are AW bits wide, so the decrement wraps 0 -> DEPTH-1.
  assign tail_m1 = tail - AW'(1);
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));

`ifdef SQ_MODE_LOCK_EN
  logic mode;

  // Loaded from the pre-edge empty flag, so the mode chosen while empty
  // stays fixed until the buffer drains again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        mode <= 1'b0;
    else if (empty) mode <= sel;
  end

  assign m = mode;
`else
  assign m = sel;
`endif

  always_comb begin
    if (empty)  data_out = '0;
    else if (m) data_out = mem[head];
    else        data_out = mem[tail_m1];
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = tail;
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    err_nxt   = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en     = 1'b1;
          tail_nxt  = tail + AW'(1);
          count_nxt = count + (AW+1)'(1);
        end else begin
          err_nxt = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          if (m) head_nxt = head + AW'(1);
          else   tail_nxt = tail_m1;
          count_nxt = count - (AW+1)'(1);
        end else begin
          err_nxt = 1'b1;
        end
      end
      2'b11: begin
        if (empty) begin
          // Pop is dropped silently; the push proceeds as a plain push.
          wr_en     = 1'b1;
          tail_nxt  = tail + AW'(1);
          count_nxt = count + (AW+1)'(1);
        end else if (!m) begin
          // Stack: overwrite the top in place.
          wr_en   = 1'b1;
          wr_addr = tail_m1;
        end else begin
          // Queue: advance both ends; legal even when full because the
          // head slot is freed in the same edge.
          wr_en    = 1'b1;
          tail_nxt = tail + AW'(1);
          head_nxt = head + AW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= data_in;
  end

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Self-checking bench for stack_queue_buffer (DATA_W = 32, DEPTH = 16).
// The reference model is an SV queue holding the stored words in push order.
module tb_stack_queue_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              push;
  logic              pop;
  logic              sel;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
  logic [AW:0]       count;
  logic              err;

  int unsigned checks;
  int unsigned errors;

  logic [DATA_W-1:0] mdl_q[$];
  logic              mdl_err;
  logic              mdl_mode;

  stack_queue_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .push     (push),
    .pop      (pop),
    .sel      (sel),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic eff_mode(input logic s);
`ifdef SQ_MODE_LOCK_EN
    return mdl_mode;
`else
    return s;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] mdl_top();
    if (mdl_q.size() == 0) return '0;
    if (eff_mode(sel)) return mdl_q[0];
    return mdl_q[mdl_q.size()-1];
  endfunction

  // Drives one request cycle, updates the model at the edge, returns #1 later
  // with requests deasserted (sel is left as driven).
  task automatic drive_cycle(input logic p, input logic o, input logic s,
                             input logic [DATA_W-1:0] d);
    logic eff;
    int   n;
    push = p; pop = o; sel = s; data_in = d;
    @(posedge clk);
    eff = eff_mode(s);
    n = mdl_q.size();
    mdl_err = 1'b0;
    if (p && !o) begin
      if (n == DEPTH) mdl_err = 1'b1;
      else mdl_q.push_back(d);
    end else if (!p && o) begin
      if (n == 0) mdl_err = 1'b1;
      else if (eff) void'(mdl_q.pop_front());
      else void'(mdl_q.pop_back());
    end else if (p && o) begin
      if (n == 0) mdl_q.push_back(d);
      else if (!eff) mdl_q[n-1] = d;
      else begin
        void'(mdl_q.pop_front());
        mdl_q.push_back(d);
      end
    end
    if (n == 0) mdl_mode = s;
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_q.delete();
    mdl_err  = 1'b0;
    mdl_mode = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || data_out !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b data_out=%0h err=%b, want 0 1 0 0 0",
               count, empty, full, data_out, err);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'(i + 10));
    checks++;
    if (count !== 3) begin
      errors++;
      $display("FAIL reset_prefill_count: got %0d want 3", count);
    end
    // Mid-cycle assertion, away from any edge, with a pending push.
    #1;
    push = 1'b1; data_in = 32'hdead;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== '0 || empty !== 1'b1 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_async: count=%0d empty=%b data_out=%0h, want 0 1 0",
               count, empty, data_out);
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    checks++;
    if (count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard_req: count=%0d empty=%b, want 0 1", count, empty);
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_q.delete(); mdl_err = 1'b0; mdl_mode = 1'b0;
  endtask

  task automatic test_stack_order();
    do_reset();
    for (int i = 1; i <= 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'(i));
    for (int i = 3; i >= 1; i--) begin
      checks++;
      if (data_out !== 32'(i)) begin
        errors++;
        $display("FAIL stack_order: data_out=%0d want %0d", data_out, i);
      end
      drive_cycle(1'b0, 1'b1, 1'b0, '0);
    end
    checks++;
    if (data_out !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL stack_drained: data_out=%0d empty=%b want 0 1", data_out, empty);
    end
    drive_cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL stack_underflow_err: err=%b want 1", err);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL stack_err_one_cycle: err=%b want 0", err);
    end
  endtask

  task automatic test_queue_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b0, 1'b1, 32'(i));
    checks++;
    if (full !== 1'b1 || count !== 16 || data_out !== 0) begin
      errors++;
      $display("FAIL queue_full: full=%b count=%0d data_out=%0d want 1 16 0", full, count, data_out);
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 32'd99);
    checks++;
    if (err !== 1'b1 || count !== 16) begin
      errors++;
      $display("FAIL queue_overflow: err=%b count=%0d want 1 16", err, count);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b1, '0);
    checks++;
    if (err !== 1'b0 || count !== 12) begin
      errors++;
      $display("FAIL queue_pop4: err=%b count=%0d want 0 12", err, count);
    end
    for (int i = 100; i < 104; i++) drive_cycle(1'b1, 1'b0, 1'b1, 32'(i));
    for (int i = 0; i < 16; i++) begin
      int want;
      want = (i < 12) ? i + 4 : 100 + (i - 12);
      checks++;
      if (data_out !== 32'(want)) begin
        errors++;
        $display("FAIL queue_drain[%0d]: data_out=%0d want %0d", i, data_out, want);
      end
      drive_cycle(1'b0, 1'b1, 1'b1, '0);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL queue_drained: empty=%b want 1", empty);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd5);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd7);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd9);
    checks++;
    if (data_out !== 32'd9 || count !== 2 || err !== 1'b0) begin
      errors++;
      $display("FAIL stack_replace: data_out=%0d count=%0d err=%b want 9 2 0", data_out, count, err);
    end
    drive_cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (data_out !== 32'd5) begin
      errors++;
      $display("FAIL stack_replace_below: data_out=%0d want 5", data_out);
    end
    do_reset();
    drive_cycle(1'b1, 1'b1, 1'b1, 32'd42);
    checks++;
    if (data_out !== 32'd42 || count !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL both_empty: data_out=%0d count=%0d err=%b want 42 1 0", data_out, count, err);
    end
    do_reset();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b0, 1'b1, 32'(i + 200));
    drive_cycle(1'b1, 1'b1, 1'b1, 32'd50);
    checks++;
    if (count !== 16 || data_out !== 32'd201 || err !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL queue_full_both: count=%0d data_out=%0d err=%b full=%b want 16 201 0 1",
               count, data_out, err, full);
    end
  endtask

  task automatic test_mode_switch();
    logic [DATA_W-1:0] want;
    do_reset();
    for (int i = 1; i <= 3; i++) drive_cycle(1'b1, 1'b0, 1'b1, 32'(i));
    sel = 1'b0;
    #1;
`ifdef SQ_MODE_LOCK_EN
    want = 32'd1;
`else
    want = 32'd3;
`endif
    checks++;
    if (data_out !== want) begin
      errors++;
      $display("FAIL mode_switch: data_out=%0d want %0d", data_out, want);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 3; i++) drive_cycle(1'b1, 1'b0, 1'b1, 32'(i + 20));
    checks++;
    if (data_out !== mdl_top()) begin
      errors++;
      $display("FAIL mode_refill: data_out=%0d want %0d", data_out, mdl_top());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic p, o, s;
      p = ($urandom_range(99) < 55);
      o = ($urandom_range(99) < 45);
      s = (i % 97 < 40) ? 1'b0 : (($urandom_range(9) < 8) ? sel : ~sel);
      drive_cycle(p, o, s, $urandom);
      checks++;
      if (count !== (AW+1)'(mdl_q.size()) || empty !== (mdl_q.size() == 0) ||
          full !== (mdl_q.size() == DEPTH) || err !== mdl_err || data_out !== mdl_top()) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d empty=%b full=%b err=%b data_out=%0h want %0d %b %b %b %0h",
                 i, count, empty, full, err, data_out, mdl_q.size(), mdl_q.size() == 0,
                 mdl_q.size() == DEPTH, mdl_err, mdl_top());
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; sel = 1'b0; data_in = '0;
    mdl_err = 1'b0; mdl_mode = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_stack_order();
    test_queue_wrap();
    test_simultaneous();
    test_mode_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
